// File: rtl/hs_npu_pkg.sv
// Shared types for the NPU post-processing slice.
// Row counts, activation modes and controller states.
package hs_npu_pkg;

  typedef logic [31:0] uword;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_CLAMP = 2'd2
  } act_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } postproc_state_t;

endpackage

// File: rtl/hs_npu_postproc_lane.sv
// One output channel: bias add, rounded requantising shift, activation.
// Two registered stages; activation is combinational after stage 2.
import hs_npu_pkg::*;

module hs_npu_postproc_lane #(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SW        = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s1_en,
  input  logic                        s2_en,
  input  logic signed [ACC_WIDTH-1:0] data_i,
  input  logic signed [ACC_WIDTH-1:0] bias_i,
  input  logic        [SW-1:0]        shift_i,
  input  act_mode_t                   act_mode_i,
  input  logic signed [OUT_WIDTH-1:0] clamp_max_i,
  output logic signed [OUT_WIDTH-1:0] res_o,
  output logic                        sat_o
);

  localparam int XW = ACC_WIDTH + 2;
  localparam logic signed [XW-1:0] MAXV =
    {{(XW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV =
    {{(XW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] sum_q;
  logic signed [XW-1:0]      shv_q;
  logic signed [XW-1:0]      ext;
  logic signed [XW-1:0]      rnd;
  logic signed [XW-1:0]      shd;
  logic signed [XW-1:0]      cm;

  // Headroom of two bits keeps sum + half-LSB from wrapping at any shift.
  always_comb begin
    ext = {sum_q[ACC_WIDTH], sum_q};
    rnd = '0;
    if (shift_i != '0)
      rnd = {{(XW-1){1'b0}}, 1'b1} << (shift_i - SW'(1));
    shd = (ext + rnd) >>> shift_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      shv_q <= '0;
    end else begin
      if (s1_en)
        sum_q <= {data_i[ACC_WIDTH-1], data_i}
               + {bias_i[ACC_WIDTH-1], bias_i};
      if (s2_en)
        shv_q <= shd;
    end
  end

  always_comb begin
    cm = {{(XW-OUT_WIDTH){clamp_max_i[OUT_WIDTH-1]}}, clamp_max_i};
    if (cm[XW-1])
      cm = '0;
    res_o = shv_q[OUT_WIDTH-1:0];
    sat_o = 1'b0;
    case (act_mode_i)
      ACT_RELU: begin
        if (shv_q[XW-1]) begin
          res_o = '0;
        end else if (shv_q > MAXV) begin
          res_o = MAXV[OUT_WIDTH-1:0];
          sat_o = 1'b1;
        end
      end
      ACT_CLAMP: begin
        if (shv_q[XW-1])
          res_o = '0;
        else if (shv_q > cm)
          res_o = cm[OUT_WIDTH-1:0];
      end
      default: begin
        if (shv_q > MAXV) begin
          res_o = MAXV[OUT_WIDTH-1:0];
          sat_o = 1'b1;
        end else if (shv_q < MINV) begin
          res_o = MINV[OUT_WIDTH-1:0];
          sat_o = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/hs_npu_postproc.sv
// NPU accumulator post-processor: job FSM, credit-based input
// flow control, LANES datapath lanes and a shared output row FIFO.
import hs_npu_pkg::*;

module hs_npu_postproc #(
  parameter int LANES      = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_i,
  input  logic                        start_i,
  input  uword                        rows_i,
  input  uword                        shift_i,
  input  act_mode_t                   act_mode_i,
  input  logic signed [OUT_WIDTH-1:0] clamp_max_i,
  input  logic signed [ACC_WIDTH-1:0] bias_i [LANES],
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic signed [ACC_WIDTH-1:0] in_data_i [LANES],
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic signed [OUT_WIDTH-1:0] out_data_o [LANES],
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        sat_o
);

  localparam int SW = $clog2(ACC_WIDTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = LANES * OUT_WIDTH;

  postproc_state_t state_q, state_d;

  uword                        rows_q;
  uword                        acc_cnt_q;
  logic [SW-1:0]               shift_q;
  act_mode_t                   mode_q;
  logic signed [OUT_WIDTH-1:0] clamp_q;
  logic signed [ACC_WIDTH-1:0] bias_q [LANES];

  logic          v1_q, v2_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          sat_q;
  logic [CW:0]   used;

  logic [RW-1:0]    mem [FIFO_DEPTH];
  logic [RW-1:0]    row_w;
  logic [RW-1:0]    rd_row;
  logic [LANES-1:0] lane_sat;

  logic accept, pop, push, start_go, last_row;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Rows in flight hold a reserved FIFO slot, so the pipeline never stalls.
  assign used = {1'b0, count_q} + {{CW{1'b0}}, v1_q}
              + {{CW{1'b0}}, v2_q};
  assign in_ready_o  = (state_q == RUN) &&
                       (used < (CW+1)'(FIFO_DEPTH));
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (count_q != '0);
  assign pop         = out_valid_o && out_ready_i;
  assign push        = v2_q && !flush_i;
  assign start_go    = start_i && (state_q == IDLE);
  assign last_row    = (acc_cnt_q + 32'd1) == rows_q;

  assign busy_o = (state_q == RUN) || (state_q == DRAIN);
  assign done_o = (state_q == DONE);
  assign sat_o  = sat_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start_i)
          state_d = (rows_i == '0) ? DONE : RUN;
      RUN:
        if (accept && last_row)
          state_d = DRAIN;
      DRAIN:
        if (!v1_q && !v2_q && (count_q == '0))
          state_d = DONE;
      DONE:
        state_d = IDLE;
    endcase
    if (flush_i)
      state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rows_q    <= '0;
      acc_cnt_q <= '0;
      shift_q   <= '0;
      mode_q    <= ACT_NONE;
      clamp_q   <= '0;
      for (int l = 0; l < LANES; l++)
        bias_q[l] <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sat_q    <= 1'b0;
    end else if (flush_i) begin
      state_q   <= IDLE;
      acc_cnt_q <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      v1_q    <= accept;
      v2_q    <= v1_q;
      if (start_go) begin
        rows_q    <= rows_i;
        shift_q   <= (shift_i >= uword'(ACC_WIDTH)) ?
                     SW'(ACC_WIDTH) : shift_i[SW-1:0];
        mode_q    <= act_mode_i;
        clamp_q   <= clamp_max_i;
        bias_q    <= bias_i;
        acc_cnt_q <= '0;
        sat_q     <= 1'b0;
      end else begin
        if (accept)
          acc_cnt_q <= acc_cnt_q + 32'd1;
        if (push && (|lane_sat))
          sat_q <= 1'b1;
      end
      if (push)
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + {{(CW-1){1'b0}}, push}
                         - {{(CW-1){1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q] <= row_w;
  end

  assign rd_row = mem[rd_ptr_q];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [OUT_WIDTH-1:0] res;

    hs_npu_postproc_lane #(
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SW        (SW)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .s1_en       (accept),
      .s2_en       (v1_q),
      .data_i      (in_data_i[l]),
      .bias_i      (bias_q[l]),
      .shift_i     (shift_q),
      .act_mode_i  (mode_q),
      .clamp_max_i (clamp_q),
      .res_o       (res),
      .sat_o       (lane_sat[l])
    );

    assign row_w[l*OUT_WIDTH +: OUT_WIDTH] = res;
    assign out_data_o[l] = out_valid_o ?
      rd_row[l*OUT_WIDTH +: OUT_WIDTH] : '0;
  end

endmodule

// File: tb/tb_hs_npu_postproc.sv
// Randomised self-checking bench for hs_npu_postproc.
// A queue model predicts every output row from plain arithmetic.
import hs_npu_pkg::*;

module tb_hs_npu_postproc;

  localparam int L = 8;
  localparam int A = 32;
  localparam int O = 16;
  localparam int D = 16;

  typedef logic [L*O-1:0] prow_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                flush_i = 1'b0;
  logic                start_i = 1'b0;
  uword                rows_i = '0;
  uword                shift_i = '0;
  act_mode_t           act_mode_i = ACT_NONE;
  logic signed [O-1:0] clamp_max_i = '0;
  logic signed [A-1:0] bias_i [L];
  logic                in_valid_i = 1'b0;
  logic                in_ready_o;
  logic signed [A-1:0] in_data_i [L];
  logic                out_valid_o;
  logic                out_ready_i = 1'b1;
  logic signed [O-1:0] out_data_o [L];
  logic                busy_o, done_o, sat_o;

  hs_npu_postproc #(
    .LANES(L), .ACC_WIDTH(A), .OUT_WIDTH(O), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .start_i(start_i), .rows_i(rows_i), .shift_i(shift_i),
    .act_mode_i(act_mode_i), .clamp_max_i(clamp_max_i),
    .bias_i(bias_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .busy_o(busy_o),
    .done_o(done_o), .sat_o(sat_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  prow_t exp_q[$];
  prow_t got_q[$];

  logic signed [A-1:0] job_data [64][L];
  logic signed [A-1:0] job_bias [L];
  logic signed [A-1:0] cfg_bias [L];
  int        cfg_shift;
  act_mode_t cfg_mode;
  longint    cfg_clamp;

  bit job_sat;
  int done_cnt, acc_cnt, cyc;
  bit fire_seen;
  int valid_pct = 100;
  int rdy_mode = 0;
  bit lat_arm, lat_wait;
  int acc_cyc, lat_meas;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic longint mv(input longint d, input longint b,
                                input int sh, input act_mode_t m,
                                input longint cm, output bit s);
    longint sum, v, c, r;
    int e;
    sum = d + b;
    e = (sh > A) ? A : sh;
    v = (e > 0) ? ((sum + (longint'(1) << (e - 1))) >>> e) : sum;
    s = 0;
    c = (cm < 0) ? 0 : cm;
    r = v;
    if (m == ACT_CLAMP) begin
      if (v < 0) r = 0;
      else if (v > c) r = c;
    end else if (m == ACT_RELU) begin
      if (v < 0) r = 0;
      else if (v > 32767) begin r = 32767; s = 1; end
    end else begin
      if (v > 32767) begin r = 32767; s = 1; end
      else if (v < -32768) begin r = -32768; s = 1; end
    end
    return r;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) out_ready_i = 1'b1;
    else if (rdy_mode == 1) out_ready_i = 1'b0;
    else out_ready_i = ($urandom % 3) != 0;
  end

  // Single compare process: model prediction vs DUT every cycle.
  always @(negedge clk) begin
    prow_t dv, ev;
    longint r;
    bit s;
    fire_seen = 0;
    if (rst_n) begin
      if (flush_i) begin
        exp_q.delete();
      end else begin
        if (out_valid_o) begin
          for (int l = 0; l < L; l++) dv[l*O +: O] = out_data_o[l];
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_row: got %h expected none", dv);
          end else begin
            chk("row_data", dv, exp_q[0]);
            if (out_ready_i) begin
              got_q.push_back(dv);
              void'(exp_q.pop_front());
            end
          end
          if (lat_wait) begin
            lat_meas = cyc - acc_cyc;
            lat_wait = 0;
          end
        end
        if (in_valid_i && in_ready_o) begin
          fire_seen = 1;
          acc_cnt++;
          for (int l = 0; l < L; l++) begin
            r = mv(in_data_i[l], cfg_bias[l], cfg_shift, cfg_mode,
                   cfg_clamp, s);
            ev[l*O +: O] = r[O-1:0];
            job_sat |= s;
          end
          exp_q.push_back(ev);
          if (lat_arm) begin
            acc_cyc = cyc;
            lat_arm = 0;
            lat_wait = 1;
          end
        end
        if (done_o) begin
          done_cnt++;
          chk("sat_at_done", sat_o, job_sat);
        end
      end
    end
  end

  task automatic start_job(input int rows, input int sh,
                           input act_mode_t m, input longint cm);
    @(posedge clk); #1;
    start_i = 1'b1;
    rows_i = rows;
    shift_i = sh;
    act_mode_i = m;
    clamp_max_i = cm[O-1:0];
    bias_i = job_bias;
    cfg_bias = job_bias;
    cfg_shift = sh;
    cfg_mode = m;
    cfg_clamp = cm;
    job_sat = 0;
    done_cnt = 0;
    acc_cnt = 0;
    got_q.delete();
    @(posedge clk); #1;
    start_i = 1'b0;
    rows_i = $urandom;
    shift_i = $urandom % 40;
    act_mode_i = act_mode_t'($urandom % 3);
    clamp_max_i = O'($urandom);
    for (int l = 0; l < L; l++) bias_i[l] = $signed($urandom);
  endtask

  task automatic feed_rows(input int rows, input bit poke);
    int idx = 0;
    int t = 0;
    in_valid_i = 1'b0;
    while (idx < rows && t < 3000) begin
      @(posedge clk); #1;
      t++;
      start_i = 1'b0;
      if (fire_seen) idx++;
      if (idx < rows) begin
        in_valid_i = ($urandom % 100) < valid_pct;
        for (int l = 0; l < L; l++) in_data_i[l] = job_data[idx][l];
        if (poke && idx == 2) begin
          start_i = 1'b1;
          rows_i = 5;
        end
      end else begin
        in_valid_i = 1'b0;
      end
    end
    in_valid_i = 1'b0;
    start_i = 1'b0;
    if (idx < rows) begin
      checks++;
      failures++;
      $display("FAIL feed_timeout: got %0d rows expected %0d", idx, rows);
    end
  endtask

  task automatic wait_done(input int rows);
    int t = 0;
    while (done_cnt == 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("rows_out", got_q.size(), rows);
    chk("model_empty", exp_q.size(), 0);
  endtask

  function automatic logic signed [A-1:0] rnd_val();
    case ($urandom % 4)
      0: return $signed($urandom);
      1: return A'(int'($urandom % 2001) - 1000);
      2: return A'(int'($urandom % 140001) - 70000);
      default: return A'(int'($urandom % 5000000) - 2500000);
    endcase
  endfunction

  initial begin
    longint r;
    bit s;
    int sh, rows;
    for (int l = 0; l < L; l++) begin
      bias_i[l] = '0;
      in_data_i[l] = '0;
      job_bias[l] = '0;
    end

    r = mv(256, 128, 8, ACT_NONE, 0, s);     chk("pin_round", r, 2);
    r = mv(-5, 0, 0, ACT_RELU, 0, s);        chk("pin_relu_neg", r, 0);
    r = mv(70000, 0, 0, ACT_RELU, 0, s);     chk("pin_relu_sat", r, 32767);
    chk("pin_relu_sat_flag", s, 1);
    r = mv(9, 0, 0, ACT_CLAMP, 6, s);        chk("pin_clamp", r, 6);
    r = mv(5, 0, 0, ACT_CLAMP, -3, s);       chk("pin_clamp_neg", r, 0);
    r = mv(-3, 0, 1, ACT_NONE, 0, s);        chk("pin_neg_round", r, -1);
    r = mv(100, 0, 40, ACT_NONE, 0, s);      chk("pin_big_shift", r, 0);
    r = mv(-100000, 0, 0, ACT_NONE, 0, s);   chk("pin_neg_sat", r, -32768);

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_sat", sat_o, 0);
    chk("rst_out_data", out_data_o[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic requantisation and pipeline latency.
    rdy_mode = 0;
    valid_pct = 100;
    for (int l = 0; l < L; l++) job_bias[l] = 32'h80;
    for (int i = 0; i < 3; i++)
      for (int l = 0; l < L; l++) job_data[i][l] = 32'h100;
    start_job(3, 8, ACT_NONE, 0);
    lat_arm = 1;
    feed_rows(3, 0);
    wait_done(3);
    for (int i = 0; i < 3 && i < got_q.size(); i++)
      chk("r039_row", got_q[i], {L{16'h0002}});
    chk("r039_latency", lat_meas, 3);
    chk("r039_sat", sat_o, 0);

    // ReLU with saturation.
    for (int l = 0; l < L; l++) begin
      job_bias[l] = '0;
      job_data[0][l] = -5;
      job_data[1][l] = 70000;
    end
    start_job(2, 0, ACT_RELU, 0);
    feed_rows(2, 0);
    wait_done(2);
    if (got_q.size() == 2) begin
      chk("r040_neg", got_q[0], '0);
      chk("r040_sat_val", got_q[1], {L{16'h7fff}});
    end
    chk("r040_sat", sat_o, 1);

    // Clamp mode.
    for (int l = 0; l < L; l++) begin
      job_data[0][l] = 3;
      job_data[1][l] = 9;
      job_data[2][l] = -2;
    end
    start_job(3, 0, ACT_CLAMP, 6);
    feed_rows(3, 0);
    wait_done(3);
    if (got_q.size() == 3) begin
      chk("r041_a", got_q[0], {L{16'd3}});
      chk("r041_b", got_q[1], {L{16'd6}});
      chk("r041_c", got_q[2], '0);
    end

    // Credit back-pressure with a blocked output.
    for (int i = 0; i < 20; i++)
      for (int l = 0; l < L; l++) job_data[i][l] = rnd_val();
    rdy_mode = 1;
    start_job(20, 4, ACT_NONE, 0);
    fork
      feed_rows(20, 0);
      begin
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("r042_accepts", acc_cnt, 16);
        chk("r042_ready_low", in_ready_o, 0);
        rdy_mode = 0;
      end
    join
    wait_done(20);

    // Flush mid-run, then a fresh two-row job.
    for (int l = 0; l < L; l++) job_data[0][l] = 70000;
    rdy_mode = 1;
    start_job(10, 0, ACT_NONE, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid_i = 1'b1;
      for (int l = 0; l < L; l++) in_data_i[l] = job_data[0][l];
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("flush_pre_sat", sat_o, 1);
    chk("flush_pre_valid", out_valid_o, 1);
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy_o, 0);
    chk("flush_valid", out_valid_o, 0);
    chk("flush_sat", sat_o, 0);
    chk("flush_no_done", done_cnt, 0);
    rdy_mode = 0;
    for (int l = 0; l < L; l++) begin
      job_data[0][l] = rnd_val();
      job_data[1][l] = rnd_val();
    end
    start_job(2, 3, ACT_NONE, 0);
    feed_rows(2, 0);
    wait_done(2);

    // Zero-row job.
    @(posedge clk); #1;
    start_i = 1'b1;
    rows_i = 0;
    done_cnt = 0;
    job_sat = 0;
    got_q.delete();
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    chk("zero_done_hi", done_o, 1);
    chk("zero_busy", busy_o, 0);
    @(negedge clk);
    chk("zero_done_lo", done_o, 0);
    repeat (4) @(negedge clk);
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_no_rows", got_q.size(), 0);

    // Randomised jobs, one with a stray start mid-run.
    valid_pct = 70;
    for (int j = 0; j < 8; j++) begin
      rows = 1 + ($urandom % 24);
      case ($urandom % 6)
        0: sh = 0;
        1: sh = 1;
        2: sh = 32;
        3: sh = 40;
        default: sh = $urandom % 33;
      endcase
      for (int l = 0; l < L; l++) job_bias[l] = rnd_val();
      for (int i = 0; i < rows; i++)
        for (int l = 0; l < L; l++) job_data[i][l] = rnd_val();
      rdy_mode = 2;
      start_job(rows, sh, act_mode_t'($urandom % 3),
                longint'(int'($urandom % 65536) - 32768));
      feed_rows(rows, j == 1);
      wait_done(rows);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
